wb_mem_slave: RTL and testbench
===============================

// Module: wb_mem_slave
// PURPOSE
// Wishbone B4 pipelined slave backed by on-chip word memory; the direct downstream target of the L1 memory access unit.
// Accepts one single-beat request per cycle and returns exactly one in-order ack/err per accepted request after fixed LATENCY.
// Programmable stall injection exercises the master's stall handling in system simulation.
// PARAMETERS
// ADDR_WIDTH   32    byte address width (= CORE_ADDR_WIDTH)
// DATA_WIDTH   32    data width (= CORE_DATA_WIDTH); SEL width = DATA_WIDTH/8
// MEM_WORDS    1024  memory depth in words; power of 2
// LATENCY      2     cycles from accept edge to ack/err; legal 1..8
// STALL_EVERY  0     0 = never stall; N>0 = assert stall 1 cycle after every N accepted requests
// PORTS
// wb_clk_i    in   1             clock
// rst_n       in   1             reset, asynchronous, active-low
// wb_cyc_i    in   1             bus cycle active
// wb_stb_i    in   1             request strobe
// wb_we_i     in   1             1 = write, 0 = read
// wb_adr_i    in   ADDR_WIDTH    byte address
// wb_dat_i    in   DATA_WIDTH    write data
// wb_sel_i    in   DATA_WIDTH/8  byte enables
// wb_stall_o  out  1             request not accepted this cycle
// wb_ack_o    out  1             normal termination, one per accepted in-range request
// wb_err_o    out  1             error termination, one per accepted out-of-range request
// wb_dat_o    out  DATA_WIDTH    read data, valid with wb_ack_o for reads; 0 otherwise
// BEHAVIOUR
// - Reset: wb_stall_o=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0; pipeline and stall counter cleared. Memory contents are not reset.
// - Accept = wb_cyc_i & wb_stb_i & ~wb_stall_o, sampled at posedge.
// - Word index = wb_adr_i[$clog2(MEM_WORDS)+1:2]; adr[1:0] ignored.
// - Out of range = wb_adr_i >= MEM_WORDS*4. Such a request produces err, no memory write, wb_dat_o=0.
// - Write at accept edge: byte i of the word is updated iff wb_sel_i[i]. Ack carries wb_dat_o=0.
// - Read at accept edge sees all writes accepted in earlier cycles, so read-after-write returns new data.
//   The read returns all bytes regardless of wb_sel_i.
// - Response delay line: LATENCY stages of {vld, err, data}, shifting every cycle; no backpressure.
//   wb_ack_o/wb_err_o/wb_dat_o are driven registered from the last stage.
//   Accept at edge k -> ack/err high during cycle k+LATENCY, for exactly one cycle per request.
//   Back-to-back accepts give back-to-back acks, in order.
// - wb_cyc_i low: all in-flight stage vld bits are cleared that cycle and no ack/err is issued.
//   Responses for an abandoned cycle are never delivered later.
// - Stall injection (STALL_EVERY=N>0): accept counter counts 0..N-1 and wraps.
//   On the accept that wraps it, wb_stall_o is registered high for the next cycle only, then low.
//   The counter holds while stalled and while wb_cyc_i is low. STALL_EVERY=0 ties wb_stall_o to 0.
// - wb_stb_i while stalled: the request is held by the master and is accepted on the first non-stall cycle; no duplicate ack.
// - At most one of wb_ack_o/wb_err_o is high in any cycle.
// - Async reset mid-burst drops all in-flight responses. Outputs go low immediately.
// STRUCTURE
// - Shared package wb_pkg: WB_ADDR_W, WB_DATA_W, WB_SEL_W localparams; typedef wb_resp_t {logic vld; logic err; logic [WB_DATA_W-1:0] dat;}.
// - Sub-module wb_resp_pipe (LATENCY-deep shift register of wb_resp_t with synchronous flush input and async reset).
// - Top level holds the memory array with byte-enable write, the address decode/range check, and the stall counter.
// TESTING
// 1 LATENCY=2: write adr 0x10 dat 0xDEADBEEF sel 0xF, then read 0x10 -> acks 2 cycles after each accept; read dat 0xDEADBEEF.
// 2 Partial write sel 0x3 dat 0x00001234 over 0xDEADBEEF at 0x10 -> subsequent read returns 0xDEAD1234.
// 3 4-beat read burst 0x100..0x10C, stb held 4 cycles, STALL_EVERY=0 -> 4 consecutive acks, data in address order.
// 4 STALL_EVERY=2, 4-beat burst -> stall high 1 cycle after 2nd accept; exactly 4 acks, order preserved, no duplicate.
// 5 Read adr MEM_WORDS*4 -> wb_err_o one cycle pulse at LATENCY, wb_ack_o stays 0, memory unchanged.
// 6 Drop wb_cyc_i 1 cycle after 2 accepts (LATENCY=3) -> no ack/err ever; next cycle request acks normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the response record carried by the slave's
// response delay line.
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  typedef struct packed {
    logic                 vld;
    logic                 err;
    logic [WB_DATA_W-1:0] dat;
  } wb_resp_t;

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone B4 pipelined single-beat bus between the L1 memory access unit
// and the on-chip memory slave.
interface wb_mem_slave_if
  import wb_pkg::*;
  ();

  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic                 wb_we_i;
  logic [WB_ADDR_W-1:0] wb_adr_i;
  logic [WB_DATA_W-1:0] wb_dat_i;
  logic [WB_SEL_W-1:0]  wb_sel_i;
  logic                 wb_stall_o;
  logic                 wb_ack_o;
  logic                 wb_err_o;
  logic [WB_DATA_W-1:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

endinterface

// File: rtl/wb_resp_pipe.sv
// Fixed-depth response delay line; a flush kills every in-flight response
// so an abandoned bus cycle can never be acknowledged later.
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic     wb_clk_i,
  input  logic     rst_n,
  input  logic     flush_i,
  input  wb_resp_t resp_i,
  output wb_resp_t resp_o
);

  wb_resp_t stage_q [LATENCY];
  wb_resp_t stage_d [LATENCY];

  always_comb begin
    for (int i = 0; i < LATENCY; i++) stage_d[i] = '0;
    stage_d[0] = resp_i;
    for (int i = 1; i < LATENCY; i++) stage_d[i] = stage_q[i-1];
    if (flush_i) begin
      for (int i = 0; i < LATENCY; i++) stage_d[i].vld = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined memory slave: byte-enabled word memory, range check,
// programmable stall injection and a fixed-latency in-order response path.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = WB_ADDR_W,
  parameter int DATA_WIDTH  = WB_DATA_W,
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 2,
  parameter int STALL_EVERY = 0
) (
  input  logic            wb_clk_i,
  input  logic            rst_n,
  wb_mem_slave_if.slave   wb
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int SE_MAX = (STALL_EVERY > 1) ? STALL_EVERY : 2;
  localparam int CNT_W  = $clog2(SE_MAX);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [IDX_W-1:0]      idx;
  logic                  oor;
  logic                  accept;
  logic                  flush;
  logic                  unused_adr_lsb;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stall_q, stall_d;
  logic                  ack_q, ack_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  wb_resp_t              resp_d, resp_pipe;

  assign idx            = wb.wb_adr_i[IDX_W+1:2];
  assign oor            = |wb.wb_adr_i[ADDR_WIDTH-1:IDX_W+2];
  assign accept         = wb.wb_cyc_i & wb.wb_stb_i & ~stall_q;
  assign flush          = ~wb.wb_cyc_i;
  assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

  // Memory is intentionally not reset; out-of-range writes never touch it.
  always_ff @(posedge wb_clk_i) begin
    if (accept && wb.wb_we_i && !oor) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (wb.wb_sel_i[i]) mem_q[idx][8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
      end
    end
  end

  // Read samples the array before this edge's write lands, so earlier writes are visible.
  always_comb begin
    resp_d     = '0;
    resp_d.vld = accept;
    resp_d.err = accept & oor;
    if (accept && !wb.wb_we_i && !oor) resp_d.dat = mem_q[idx];
  end

  always_comb begin
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    if (STALL_EVERY > 0 && accept) begin
      if (cnt_q == CNT_W'(STALL_EVERY - 1)) begin
        cnt_d   = '0;
        stall_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  wb_resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .resp_i   (resp_d),
    .resp_o   (resp_pipe)
  );

  always_comb begin
    ack_d = resp_pipe.vld & ~resp_pipe.err & ~flush;
    err_d = resp_pipe.vld &  resp_pipe.err & ~flush;
    dat_d = ack_d ? resp_pipe.dat : '0;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign wb.wb_stall_o = stall_q;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: three instances (LATENCY=2, LATENCY=2 with
// STALL_EVERY=2, LATENCY=3) driven one at a time from a shared master.
module tb_wb_mem_slave;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
  logic [31:0] d_adr = '0, d_dat = '0;
  logic [3:0]  d_sel = '0;
  int          tgt = 0;

  logic        o_stall [3];
  logic        o_ack   [3];
  logic        o_err   [3];
  logic [31:0] o_dat   [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    wb_mem_slave_if bus ();
    assign bus.wb_cyc_i = d_cyc && (tgt == k);
    assign bus.wb_stb_i = d_stb && (tgt == k);
    assign bus.wb_we_i  = d_we;
    assign bus.wb_adr_i = d_adr;
    assign bus.wb_dat_i = d_dat;
    assign bus.wb_sel_i = d_sel;
    assign o_stall[k]   = bus.wb_stall_o;
    assign o_ack[k]     = bus.wb_ack_o;
    assign o_err[k]     = bus.wb_err_o;
    assign o_dat[k]     = bus.wb_dat_o;

    wb_mem_slave #(
      .MEM_WORDS   (1024),
      .LATENCY     ((k == 2) ? 3 : 2),
      .STALL_EVERY ((k == 1) ? 2 : 0)
    ) u_dut (
      .wb_clk_i (clk),
      .rst_n    (rst_n),
      .wb       (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int k, input logic a, input logic e,
                         input logic [31:0] d);
    chk({tag, " ack"}, 32'(o_ack[k]), 32'(a));
    chk({tag, " err"}, 32'(o_err[k]), 32'(e));
    chk({tag, " dat"}, o_dat[k], d);
  endtask

  // Present one bus vector, then return at the falling edge after it was sampled.
  task automatic drive(input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    d_cyc = c; d_stb = s; d_we = w; d_adr = a; d_dat = d; d_sel = sl;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    int  r;
    logic stalled;
    logic [31:0] exp_d;

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_rsp($sformatf("reset dut%0d", k), k, 1'b0, 1'b0, 32'h0);
      chk($sformatf("reset dut%0d stall", k), 32'(o_stall[k]), 32'h0);
    end
    rst_n = 1'b1;

    // Full write then read-back, LATENCY=2
    tgt = 0;
    drive(1, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF); chk_rsp("t1 e1", 0, 0, 0, 0);
    drive(1, 1, 0, 32'h10, 32'h0, 4'hF);        chk_rsp("t1 e2", 0, 0, 0, 0);
    idle();                                     chk_rsp("t1 wr ack", 0, 1, 0, 0);
    idle();                                     chk_rsp("t1 rd ack", 0, 1, 0, 32'hDEADBEEF);
    idle();                                     chk_rsp("t1 quiet", 0, 0, 0, 0);

    // Partial write followed immediately by read-after-write
    drive(1, 1, 1, 32'h10, 32'h00001234, 4'h3); chk_rsp("t2 e1", 0, 0, 0, 0);
    drive(1, 1, 0, 32'h12, 32'h0, 4'h1);        chk_rsp("t2 e2", 0, 0, 0, 0);
    idle();                                     chk_rsp("t2 wr ack", 0, 1, 0, 0);
    idle();                                     chk_rsp("t2 rd ack", 0, 1, 0, 32'hDEAD1234);
    idle();                                     chk_rsp("t2 quiet", 0, 0, 0, 0);

    // 4 writes then 4-beat read burst: acks back-to-back at edges 3..10
    for (int j = 1; j <= 11; j++) begin
      if (j <= 4)      drive(1, 1, 1, 32'h100 + 32'(4*(j-1)), word(j-1), 4'hF);
      else if (j <= 8) drive(1, 1, 0, 32'h100 + 32'(4*(j-5)), 32'h0, 4'h0);
      else             idle();
      exp_d = (j >= 7 && j <= 10) ? word(j-7) : 32'h0;
      chk_rsp($sformatf("t3 e%0d", j), 0, (j >= 3 && j <= 10), 1'b0, exp_d);
    end

    // Out-of-range read and write produce single err pulses and leave memory alone
    drive(1, 1, 1, 32'h0, 32'h0000CAFE, 4'hF);    chk_rsp("t5 e1", 0, 0, 0, 0);
    drive(1, 1, 0, 32'h1000, 32'h0, 4'hF);        chk_rsp("t5 e2", 0, 0, 0, 0);
    drive(1, 1, 1, 32'h1000, 32'hBADBAD00, 4'hF); chk_rsp("t5 wr0 ack", 0, 1, 0, 0);
    drive(1, 1, 0, 32'h0, 32'h0, 4'hF);           chk_rsp("t5 rd err", 0, 0, 1, 0);
    idle();                                       chk_rsp("t5 wr err", 0, 0, 1, 0);
    idle();                                       chk_rsp("t5 rd0 ack", 0, 1, 0, 32'h0000CAFE);
    idle();                                       chk_rsp("t5 quiet", 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);

    // STALL_EVERY=2: master holds each request through the injected stall
    tgt = 1;
    r = 0;
    for (int j = 1; j <= 14; j++) begin
      stalled = o_stall[1];
      if (r < 4)      drive(1, 1, 1, 32'h100 + 32'(4*r), word(r), 4'hF);
      else if (r < 8) drive(1, 1, 0, 32'h100 + 32'(4*(r-4)), 32'h0, 4'h0);
      else            idle();
      if (!stalled && r < 8) r++;
      case (j)
        9:       exp_d = word(0);
        10:      exp_d = word(1);
        12:      exp_d = word(2);
        13:      exp_d = word(3);
        default: exp_d = 32'h0;
      endcase
      chk($sformatf("t4 e%0d stall", j), 32'(o_stall[1]), 32'(j inside {2, 5, 8, 11}));
      chk_rsp($sformatf("t4 e%0d", j), 1, (j inside {3, 4, 6, 7, 9, 10, 12, 13}), 1'b0, exp_d);
    end
    chk("t4 accepted", 32'(r), 32'd8);
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);

    // LATENCY=3: drop cyc after two accepts; only the later read is answered
    tgt = 2;
    for (int j = 1; j <= 8; j++) begin
      case (j)
        1:       drive(1, 1, 1, 32'h20, 32'h1, 4'hF);
        2:       drive(1, 1, 1, 32'h24, 32'h2, 4'hF);
        3:       drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        4:       drive(1, 1, 0, 32'h20, 32'h0, 4'hF);
        default: idle();
      endcase
      chk_rsp($sformatf("t6 e%0d", j), 2, (j == 7), 1'b0, (j == 7) ? 32'h1 : 32'h0);
    end
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Asynchronous reset while responses are in flight
    tgt = 0;
    drive(1, 1, 0, 32'h10, 32'h0, 4'hF); chk_rsp("rst e1", 0, 0, 0, 0);
    drive(1, 1, 0, 32'h10, 32'h0, 4'hF); chk_rsp("rst e2", 0, 0, 0, 0);
    idle();                              chk_rsp("rst e3", 0, 1, 0, 32'hDEAD1234);
    rst_n = 1'b0;
    #1;
    chk_rsp("rst async", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();                              chk_rsp("rst after1", 0, 0, 0, 0);
    idle();                              chk_rsp("rst after2", 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
